tc_ram_stack_ctrl: RTL and testbench

- Request-driven LIFO controller sitting directly upstream of the TC RAM component.
- Turns push/pop/peek/clear requests into the RAM's load/save/address/in strobes and captures the RAM's out data.
- Maintains the stack pointer, fill count and full/empty flags, and returns one response per request over a valid/ready handshake.

---
 rtl/tc_stack_pkg.sv | 24 ++
 rtl/tc_stack_ptr.sv | 62 ++++++
 rtl/tc_ram_stack_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_tc_ram_stack_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tc_stack_pkg.sv
// -----------------------------------------------------------------------------
// tc_stack_pkg
// Shared definitions for the TC RAM stack controller: request opcode encoding
// and the controller FSM state type.
// -----------------------------------------------------------------------------
package tc_stack_pkg;

    // Request opcodes carried on req_op.
    typedef enum logic [1:0] {
        OP_PUSH  = 2'b00,
        OP_POP   = 2'b01,
        OP_PEEK  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    // Controller FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_READ  = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

endpackage : tc_stack_pkg

// File: rtl/tc_stack_ptr.sv
// -----------------------------------------------------------------------------
// tc_stack_ptr
// Stack pointer / fill count register. The stack pointer is the low ADDR_W
// bits of the count: slot sp is the next free slot, slot sp-1 is the top.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   inc_i           push committed: count + 1
//   dec_i           pop committed:  count - 1
//   clr_i           clear: count = 0 (wins over inc/dec)
//   sp_o            stack pointer (count modulo 2^ADDR_W)
//   count_o         number of stored entries, 0..DEPTH
//   full_o/empty_o  count == DEPTH / count == 0
// -----------------------------------------------------------------------------
module tc_stack_ptr #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    input  logic              dec_i,
    input  logic              clr_i,
    output logic [ADDR_W-1:0] sp_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

    logic [ADDR_W:0] count_q;
    logic [ADDR_W:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + ONE_C;
        end else if (dec_i) begin
            count_d = count_q - ONE_C;
        end
    end

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // its inputs as they were before the edge, independent of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign sp_o    = count_q[ADDR_W-1:0];
    assign count_o = count_q;
    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);

endmodule : tc_stack_ptr

// File: rtl/tc_ram_stack_ctrl.sv
// -----------------------------------------------------------------------------
// tc_ram_stack_ctrl
// Request-driven LIFO controller in front of a single-port TC RAM. Each
// accepted push/pop/peek/clear request produces exactly one response.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake
//   req_op, req_data              opcode (tc_stack_pkg::op_e), push data
//   rsp_valid/rsp_ready           response handshake
//   rsp_data, rsp_err             returned value, overflow/underflow flag
//   count, full, empty            stack occupancy
//   ram_load, ram_save            RAM read / write strobes
//   ram_address, ram_in, ram_out  RAM address, write data, read data
//
// All outputs come straight from registers except full/empty, which are
// decoded from count.
// -----------------------------------------------------------------------------
module tc_ram_stack_ctrl
    import tc_stack_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned BASE   = 0,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              ram_load,
    output logic              ram_save,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_in,
    input  logic [DATA_W-1:0] ram_out
);

    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);
    localparam logic [1:0]        RD_LAT_C = 2'(RD_LAT);

    state_e            state_q,     state_d;
    op_e               op_q,        op_d;
    logic [DATA_W-1:0] data_q,      data_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
    logic              rsp_err_q,   rsp_err_d;
    logic              ram_load_q,  ram_load_d;
    logic              ram_save_q,  ram_save_d;
    logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
    logic [DATA_W-1:0] ram_in_q,    ram_in_d;
    // Remaining READ cycles after the current one.
    logic [1:0]        rd_cnt_q,    rd_cnt_d;

    logic              ptr_inc, ptr_dec, ptr_clr;
    logic [ADDR_W-1:0] sp;

    tc_stack_ptr #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ptr (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (ptr_inc),
        .dec_i   (ptr_dec),
        .clr_i   (ptr_clr),
        .sp_o    (sp),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the case statements leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        ram_load_d  = 1'b0;
        ram_save_d  = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_in_d    = ram_in_q;
        rd_cnt_d    = rd_cnt_q;
        ptr_inc     = 1'b0;
        ptr_dec     = 1'b0;
        ptr_clr     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d   = op_e'(req_op);
                    data_d = req_data;
                    // Error and clear responses go straight to RESP; the
                    // strobes are set up here so they are registered for the
                    // whole WRITE/READ phase.
                    case (op_e'(req_op))
                        OP_PUSH: begin
                            if (full) begin
                                state_d     = ST_RESP;
                                rsp_valid_d = 1'b1;
                                rsp_err_d   = 1'b1;
                                rsp_data_d  = '0;
                            end else begin
                                state_d    = ST_WRITE;
                                ram_save_d = 1'b1;
                                ram_addr_d = BASE_A + sp;
                                ram_in_d   = req_data;
                            end
                        end
                        OP_POP, OP_PEEK: begin
                            if (empty) begin
                                state_d     = ST_RESP;
                                rsp_valid_d = 1'b1;
                                rsp_err_d   = 1'b1;
                                rsp_data_d  = '0;
                            end else begin
                                state_d    = ST_READ;
                                ram_load_d = 1'b1;
                                ram_addr_d = BASE_A + sp - ONE_A;
                                rd_cnt_d   = RD_LAT_C;
                            end
                        end
                        OP_CLEAR: begin
                            ptr_clr     = 1'b1;
                            state_d     = ST_RESP;
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b0;
                            rsp_data_d  = '0;
                        end
                    endcase
                end
            end

            ST_WRITE: begin
                ptr_inc     = 1'b1;
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_data_d  = data_q;
            end

            ST_READ: begin
                if (rd_cnt_q == 2'd0) begin
                    // Final READ cycle: ram_out now reflects the load issued
                    // RD_LAT cycles ago.
                    ptr_dec     = (op_q == OP_POP);
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = ram_out;
                end else begin
                    rd_cnt_d   = rd_cnt_q - 2'd1;
                    ram_load_d = 1'b1;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    // Asynchronous reset drops ram_save/ram_load immediately, so an in-flight
    // write never completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_PUSH;
            data_q      <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            ram_load_q  <= 1'b0;
            ram_save_q  <= 1'b0;
            ram_addr_q  <= '0;
            ram_in_q    <= '0;
            rd_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            ram_load_q  <= ram_load_d;
            ram_save_q  <= ram_save_d;
            ram_addr_q  <= ram_addr_d;
            ram_in_q    <= ram_in_d;
            rd_cnt_q    <= rd_cnt_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign ram_load    = ram_load_q;
    assign ram_save    = ram_save_q;
    assign ram_address = ram_addr_q;
    assign ram_in      = ram_in_q;

endmodule : tc_ram_stack_ctrl

// File: tb/tb_tc_ram_stack_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tc_ram_stack_ctrl
// Directed bench for tc_ram_stack_ctrl. Instance 0 uses default parameters
// (BASE 0, DEPTH 256, RD_LAT 1); instance 1 uses DEPTH 4, BASE 0xFE to cover
// address wrap and the full boundary. Each instance drives a behavioural RAM
// with one cycle of read latency.
// -----------------------------------------------------------------------------
module tb_tc_ram_stack_ctrl;
    import tc_stack_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req_valid   [2];
    logic       req_ready   [2];
    logic [1:0] req_op      [2];
    logic [7:0] req_data    [2];
    logic       rsp_valid   [2];
    logic       rsp_ready   [2];
    logic [7:0] rsp_data    [2];
    logic       rsp_err     [2];
    logic [8:0] count       [2];
    logic       full        [2];
    logic       empty       [2];
    logic       ram_load    [2];
    logic       ram_save    [2];
    logic [7:0] ram_address [2];
    logic [7:0] ram_in      [2];
    logic [7:0] ram_out     [2];

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];

    int n_tests = 0;
    int n_fail  = 0;

    tc_ram_stack_ctrl u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_op(req_op[0]), .req_data(req_data[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
        .count(count[0]), .full(full[0]), .empty(empty[0]),
        .ram_load(ram_load[0]), .ram_save(ram_save[0]),
        .ram_address(ram_address[0]), .ram_in(ram_in[0]), .ram_out(ram_out[0])
    );

    tc_ram_stack_ctrl #(.DEPTH(4), .BASE(8'hFE)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_op(req_op[1]), .req_data(req_data[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
        .count(count[1]), .full(full[1]), .empty(empty[1]),
        .ram_load(ram_load[1]), .ram_save(ram_save[1]),
        .ram_address(ram_address[1]), .ram_in(ram_in[1]), .ram_out(ram_out[1])
    );

    // RAM models: synchronous write, read data one cycle after the load.
    always @(posedge clk) begin
        if (ram_save[0]) mem0[ram_address[0]] <= ram_in[0];
        if (ram_load[0]) ram_out[0] <= mem0[ram_address[0]];
    end
    always @(posedge clk) begin
        if (ram_save[1]) mem1[ram_address[1]] <= ram_in[1];
        if (ram_load[1]) ram_out[1] <= mem1[ram_address[1]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues one request on instance s and checks the response and the RAM
    // strobes seen between acceptance and response.
    task automatic do_req(input int s, input op_e op, input logic [7:0] d,
                          input logic [7:0] exp_d, input logic exp_e,
                          input int exp_lat, input int exp_sv, input int exp_ld,
                          input logic [7:0] exp_a, input string tag);
        int         lat  = 0;
        int         sv   = 0;
        int         ld   = 0;
        int         both = 0;
        logic [7:0] a    = '0;
        logic [7:0] win  = '0;
        bit         got  = 1'b0;
        @(negedge clk);
        req_valid[s] = 1'b1;
        req_op[s]    = op;
        req_data[s]  = d;
        @(posedge clk);
        #1 req_valid[s] = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (rsp_valid[s]) begin
                got = 1'b1;
            end else begin
                if (ram_save[s]) begin sv++; a = ram_address[s]; win = ram_in[s]; end
                if (ram_load[s]) begin ld++; a = ram_address[s]; end
                if (ram_save[s] && ram_load[s]) both++;
            end
        end
        check({tag, ".rsp_seen"}, 32'(got), 32'd1);
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".data"}, 32'(rsp_data[s]), 32'(exp_d));
        check({tag, ".err"}, 32'(rsp_err[s]), 32'(exp_e));
        check({tag, ".save_cycles"}, 32'(sv), 32'(exp_sv));
        check({tag, ".load_cycles"}, 32'(ld), 32'(exp_ld));
        check({tag, ".strobe_overlap"}, 32'(both), 32'd0);
        if (exp_sv + exp_ld > 0) check({tag, ".addr"}, 32'(a), 32'(exp_a));
        if (exp_sv > 0) check({tag, ".ram_in"}, 32'(win), 32'(d));
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".req_ready"}, 32'(req_ready[0]), 32'd1);
        check({tag, ".rsp_valid"}, 32'(rsp_valid[0]), 32'd0);
        check({tag, ".rsp_err"}, 32'(rsp_err[0]), 32'd0);
        check({tag, ".rsp_data"}, 32'(rsp_data[0]), 32'd0);
        check({tag, ".count"}, 32'(count[0]), 32'd0);
        check({tag, ".empty"}, 32'(empty[0]), 32'd1);
        check({tag, ".full"}, 32'(full[0]), 32'd0);
        check({tag, ".ram_load"}, 32'(ram_load[0]), 32'd0);
        check({tag, ".ram_save"}, 32'(ram_save[0]), 32'd0);
        check({tag, ".ram_address"}, 32'(ram_address[0]), 32'd0);
        check({tag, ".ram_in"}, 32'(ram_in[0]), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0;
            req_op[s]    = 2'b00;
            req_data[s]  = 8'h00;
            rsp_ready[s] = 1'b1;
        end
        repeat (2) @(negedge clk);
        check("in_reset.ram_save", 32'(ram_save[0]), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("reset");

        // Push/peek/pop at BASE 0.
        do_req(0, OP_PUSH, 8'h01, 8'h01, 1'b0, 2, 1, 0, 8'h00, "push1");
        do_req(0, OP_PUSH, 8'h02, 8'h02, 1'b0, 2, 1, 0, 8'h01, "push2");
        check("push2.count", 32'(count[0]), 32'd2);
        do_req(0, OP_PEEK, 8'h00, 8'h02, 1'b0, 3, 0, 2, 8'h01, "peek");
        check("peek.count", 32'(count[0]), 32'd2);
        do_req(0, OP_POP, 8'h00, 8'h02, 1'b0, 3, 0, 2, 8'h01, "pop1");
        do_req(0, OP_POP, 8'h00, 8'h01, 1'b0, 3, 0, 2, 8'h00, "pop2");
        check("pop2.empty", 32'(empty[0]), 32'd1);
        check("pop2.count", 32'(count[0]), 32'd0);

        // Underflow.
        do_req(0, OP_POP, 8'h00, 8'h00, 1'b1, 1, 0, 0, 8'h00, "pop_empty");
        check("pop_empty.count", 32'(count[0]), 32'd0);

        // Response back-pressure.
        rsp_ready[0] = 1'b0;
        do_req(0, OP_PUSH, 8'hA5, 8'hA5, 1'b0, 2, 1, 0, 8'h00, "hold.push");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold.rsp_valid", 32'(rsp_valid[0]), 32'd1);
            check("hold.rsp_data", 32'(rsp_data[0]), 32'hA5);
            check("hold.req_ready", 32'(req_ready[0]), 32'd0);
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1 check("hold.release_ready", 32'(req_ready[0]), 32'd1);
        do_req(0, OP_POP, 8'h00, 8'hA5, 1'b0, 3, 0, 2, 8'h00, "hold.pop");

        // Clear.
        do_req(0, OP_PUSH, 8'h11, 8'h11, 1'b0, 2, 1, 0, 8'h00, "clr.push1");
        do_req(0, OP_PUSH, 8'h22, 8'h22, 1'b0, 2, 1, 0, 8'h01, "clr.push2");
        do_req(0, OP_CLEAR, 8'h00, 8'h00, 1'b0, 1, 0, 0, 8'h00, "clear");
        check("clear.count", 32'(count[0]), 32'd0);
        check("clear.empty", 32'(empty[0]), 32'd1);

        // Wrap and full on instance 1 (DEPTH 4, BASE 0xFE).
        do_req(1, OP_PUSH, 8'h10, 8'h10, 1'b0, 2, 1, 0, 8'hFE, "wrap.push0");
        do_req(1, OP_PUSH, 8'h11, 8'h11, 1'b0, 2, 1, 0, 8'hFF, "wrap.push1");
        do_req(1, OP_PUSH, 8'h12, 8'h12, 1'b0, 2, 1, 0, 8'h00, "wrap.push2");
        check("wrap.not_full_yet", 32'(full[1]), 32'd0);
        do_req(1, OP_PUSH, 8'h13, 8'h13, 1'b0, 2, 1, 0, 8'h01, "wrap.push3");
        check("wrap.full", 32'(full[1]), 32'd1);
        check("wrap.count", 32'(count[1]), 32'd4);
        do_req(1, OP_PUSH, 8'h14, 8'h00, 1'b1, 1, 0, 0, 8'h00, "wrap.overflow");
        check("wrap.overflow_count", 32'(count[1]), 32'd4);
        do_req(1, OP_POP, 8'h00, 8'h13, 1'b0, 3, 0, 2, 8'h01, "wrap.pop");
        check("wrap.pop_full", 32'(full[1]), 32'd0);
        check("wrap.pop_count", 32'(count[1]), 32'd3);

        // Reset in the middle of a WRITE.
        do_req(0, OP_PUSH, 8'h33, 8'h33, 1'b0, 2, 1, 0, 8'h00, "mw.push");
        check("mw.count_before", 32'(count[0]), 32'd1);
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_op[0]    = OP_PUSH;
        req_data[0]  = 8'h44;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        check("mw.save_on", 32'(ram_save[0]), 32'd1);
        #2 rst = 1'b0;
        #1 check("mw.save_drop", 32'(ram_save[0]), 32'd0);
        check("mw.count_in_reset", 32'(count[0]), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("mw.after");
        do_req(0, OP_POP, 8'h00, 8'h00, 1'b1, 1, 0, 0, 8'h00, "mw.pop_empty");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_tc_ram_stack_ctrl
